// File: rtl/tag_ram_ctrl.sv
// tag_ram_ctrl: initiator-side controller for the FIX parser's dual-port tag RAM.
//
// Accepts tag writes and tag reads over valid/ready handshakes. It drives RAM
// port 0 as write-only and RAM port 1 as read-only. Read data comes back in
// request order through a small response FIFO. The RAM is swept to zero after
// reset and whenever clear_start is pulsed while idle.
//
// Ports:
//   clk, rst_n                  clock; asynchronous active-low reset
//   wr_valid/wr_ready           write request handshake; wr_addr, wr_data
//   rd_valid/rd_ready           read request handshake; rd_addr
//   rsp_valid/rsp_ready         read response handshake; rsp_addr, rsp_data
//   clear_start, clear_busy     zero-sweep request pulse and sweep status
//   ram_*_0                     RAM port 0 (writes only); ram_data_0 is driven during writes
//   ram_*_1                     RAM port 1 (reads only); ram_data_1 is never driven here
module tag_ram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic [DATA_WIDTH-1:0] rsp_data,
  input  logic                  clear_start,
  output logic                  clear_busy,
  output logic [ADDR_WIDTH-1:0] ram_address_0,
  output logic                  ram_cs_0,
  output logic                  ram_we_0,
  output logic                  ram_oe_0,
  inout  wire  [DATA_WIDTH-1:0] ram_data_0,
  output logic [ADDR_WIDTH-1:0] ram_address_1,
  output logic                  ram_cs_1,
  output logic                  ram_we_1,
  output logic                  ram_oe_1,
  inout  wire  [DATA_WIDTH-1:0] ram_data_1
);

  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

  // ---------------- control FSM ----------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (clear_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  logic clearing, idle;
  assign clearing   = (state_q == ST_CLEAR);
  assign idle       = (state_q == ST_IDLE);
  assign clear_busy = clearing;

  // ---------------- write path (RAM port 0) ----------------
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wdata_q;

  assign wr_ready = idle;
  assign wr_fire  = wr_valid & wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cs_0      <= 1'b0;
      ram_we_0      <= 1'b0;
      ram_address_0 <= '0;
      wdata_q       <= '0;
    end else begin
      ram_cs_0 <= clearing | wr_fire;
      ram_we_0 <= clearing | wr_fire;
      if (clearing) begin
        ram_address_0 <= clr_cnt_q;
        wdata_q       <= '0;
      end else if (wr_fire) begin
        ram_address_0 <= wr_addr;
        wdata_q       <= wr_data;
      end
    end
  end

  assign ram_oe_0   = 1'b0;
  assign ram_data_0 = (ram_cs_0 & ram_we_0) ? wdata_q : {DATA_WIDTH{1'bz}};

  // ---------------- read path (RAM port 1) ----------------
  // Stage A presents the address; the RAM returns data during stage B.
  logic                  rd_fire;
  logic                  a_v, b_v;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic                  b_fwd;
  logic [DATA_WIDTH-1:0] b_fwd_data;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;

  // Credit check counts reads still in the pipe so a capture never overflows.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(a_v) + (CW+1)'(b_v);
  assign rd_ready  = idle && (occupancy < (CW+1)'(RSP_DEPTH));
  assign rd_fire   = rd_valid & rd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_v           <= 1'b0;
      b_v           <= 1'b0;
      ram_address_1 <= '0;
      ram_cs_1      <= 1'b0;
      ram_oe_1      <= 1'b0;
      b_addr        <= '0;
      b_fwd         <= 1'b0;
      b_fwd_data    <= '0;
    end else begin
      a_v      <= rd_fire;
      b_v      <= a_v;
      // The RAM drives ram_data_1 only while selected, so hold cs/oe across A and B.
      ram_cs_1 <= rd_fire | a_v;
      ram_oe_1 <= rd_fire | a_v;
      if (rd_fire) ram_address_1 <= rd_addr;
      if (a_v) begin
        b_addr     <= ram_address_1;
        // The RAM reads the old word when port 0 writes the same address in
        // the same cycle; substitute the write data so the read sees it.
        b_fwd      <= ram_cs_0 & ram_we_0 & (ram_address_0 == ram_address_1);
        b_fwd_data <= wdata_q;
      end
    end
  end

  assign ram_we_1   = 1'b0;
  assign ram_data_1 = {DATA_WIDTH{1'bz}};

  // ---------------- response FIFO ----------------
  logic [ADDR_WIDTH-1:0] fifo_addr [RSP_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic                  push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign push = b_v;
  assign pop  = rsp_valid & rsp_ready;

  // NOTE: the storage array has no reset; the pointers and count are reset,
  // and the outputs are gated by rsp_valid, so stale contents are never seen.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= b_addr;
      fifo_data[wr_ptr] <= b_fwd ? b_fwd_data : ram_data_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      fifo_count <= fifo_count + CW'(1);
      else if (!push && pop) fifo_count <= fifo_count - CW'(1);
    end
  end

  assign rsp_valid = (fifo_count != '0);
  assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr] : '0;
  assign rsp_data  = rsp_valid ? fifo_data[rd_ptr] : '0;

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Directed testbench for tag_ram_ctrl with a behavioral dual-port RAM model.
module tb_tag_ram_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int RD = 4;

  logic          clk, rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, rsp_addr;
  logic [DW-1:0] wr_data, rsp_data;
  logic          rsp_valid, rsp_ready, clear_start, clear_busy;
  logic [AW-1:0] ram_address_0, ram_address_1;
  logic          ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1;
  wire  [DW-1:0] ram_data_0, ram_data_1;

  int n_checks = 0;
  int n_err    = 0;

  tag_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(RD)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .clear_start(clear_start), .clear_busy(clear_busy),
    .ram_address_0(ram_address_0), .ram_cs_0(ram_cs_0), .ram_we_0(ram_we_0),
    .ram_oe_0(ram_oe_0), .ram_data_0(ram_data_0),
    .ram_address_1(ram_address_1), .ram_cs_1(ram_cs_1), .ram_we_1(ram_we_1),
    .ram_oe_1(ram_oe_1), .ram_data_1(ram_data_1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: port 0 writes on the edge, port 1 registers a read each selected
  // cycle and drives it while cs/oe are high. Power-up contents are non-zero.
  logic [DW-1:0] mem [1 << AW];
  logic [DW-1:0] q1;
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'hA5A5_0000 | i;
    q1 = '0;
  end
  always @(posedge clk) begin
    if (ram_cs_0 && ram_we_0) mem[ram_address_0] <= ram_data_0;
    if (ram_cs_1 && ram_oe_1) q1 <= mem[ram_address_1];
  end
  assign ram_data_1 = (ram_cs_1 && ram_oe_1) ? q1 : {DW{1'bz}};

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called right after the accepting edge; waits for the response, checks it,
  // then lets it pop (rsp_ready must be 1).
  task automatic wait_rsp(input string tag, input logic [AW-1:0] ea,
                          input logic [DW-1:0] ed, input int elat);
    int lat;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      tick();
      lat++;
    end
    check($sformatf("%s.valid", tag), 32'(rsp_valid), 32'd1);
    check($sformatf("%s.addr", tag), 32'(rsp_addr), 32'(ea));
    check($sformatf("%s.data", tag), rsp_data, ed);
    if (elat >= 0) check($sformatf("%s.latency", tag), lat, elat);
    tick();
  endtask

  // Counts remaining busy cycles from the current point and checks that both
  // readies stay low during the sweep and rise once it ends.
  task automatic sweep(input string tag, input int exp_cycles);
    int n, rdy_hi;
    n = 0;
    rdy_hi = 0;
    while (clear_busy && n < 1000) begin
      if (wr_ready || rd_ready) rdy_hi++;
      n++;
      tick();
    end
    check($sformatf("%s.busy_cycles", tag), n, exp_cycles);
    check($sformatf("%s.ready_during_busy", tag), rdy_hi, 0);
    check($sformatf("%s.wr_ready_after", tag), 32'(wr_ready), 32'd1);
    check($sformatf("%s.rd_ready_after", tag), 32'(rd_ready), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    rd_valid = 1'b1;
    rd_addr  = a;
    tick();
    rd_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    int  acc, got, stale, next_a;
    logic r;

    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    clear_start = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;

    // --- reset values ---
    tick();
    tick();
    check("rst.wr_ready",   32'(wr_ready), 32'd0);
    check("rst.rd_ready",   32'(rd_ready), 32'd0);
    check("rst.rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst.rsp_addr",   32'(rsp_addr), 32'd0);
    check("rst.rsp_data",   rsp_data, 32'd0);
    check("rst.clear_busy", 32'(clear_busy), 32'd1);
    check("rst.ram_ctl",    {26'd0, ram_cs_0, ram_we_0, ram_oe_0, ram_cs_1, ram_we_1, ram_oe_1}, 32'd0);
    check("rst.ram_addr",   {16'd0, ram_address_0, ram_address_1}, 32'd0);

    // --- release: first clear write on the first edge, 256 busy cycles ---
    rst_n = 1'b1;
    tick();
    check("sweep0.cs_we", {30'd0, ram_cs_0, ram_we_0}, 32'd3);
    check("sweep0.addr",  32'(ram_address_0), 32'd0);
    check("sweep0.data",  ram_data_0, 32'd0);
    check("sweep0.oe0",   32'(ram_oe_0), 32'd0);
    sweep("sweep0", 255);

    // --- read of a cleared address ---
    do_read(8'h05);
    wait_rsp("rd05", 8'h05, 32'h0000_0000, 2);
    check("rd05.valid_drop", 32'(rsp_valid), 32'd0);

    // --- write then read on the following edge ---
    do_write(8'h10, 32'hDEAD_BEEF);
    check("wr10.bus", {ram_cs_0, ram_we_0, 22'd0, ram_address_0}, 32'hC000_0010);
    do_read(8'h10);
    check("wr10.mem", mem[8'h10], 32'hDEAD_BEEF);
    wait_rsp("rd10", 8'h10, 32'hDEAD_BEEF, 2);

    // --- same-edge write and read at one address: forwarded ---
    wr_valid = 1'b1; wr_addr = 8'h20; wr_data = 32'h1234_5678;
    rd_valid = 1'b1; rd_addr = 8'h20;
    tick();
    wr_valid = 1'b0; rd_valid = 1'b0;
    wait_rsp("fwd20", 8'h20, 32'h1234_5678, 2);

    // --- write accepted after the read is not visible to it ---
    do_read(8'h30);
    do_write(8'h30, 32'h0000_0055);
    wait_rsp("late30", 8'h30, 32'h0000_0000, -1);

    // --- back-to-back writes 1..8, then backpressured read stream ---
    for (int i = 1; i <= 8; i++) begin
      wr_valid = 1'b1; wr_addr = AW'(i); wr_data = 32'hA000_0000 | i;
      tick();
    end
    wr_valid = 1'b0;

    rsp_ready = 1'b0;
    acc = 0; next_a = 1;
    rd_valid = 1'b1; rd_addr = 8'h01;
    for (int c = 0; c < 10; c++) begin
      r = rd_ready;
      tick();
      if (r) begin
        acc++;
        next_a++;
        rd_addr = AW'(next_a);
      end
    end
    check("stream.accepts",  acc, 4);
    check("stream.rd_ready", 32'(rd_ready), 32'd0);
    check("stream.head",     32'(rsp_addr), 32'h01);

    rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      if (rsp_valid) begin
        check($sformatf("stream.addr%0d", got + 1), 32'(rsp_addr), 32'(got + 1));
        check($sformatf("stream.data%0d", got + 1), rsp_data, 32'hA000_0000 | (got + 1));
        got++;
      end
      r = rd_valid && rd_ready;
      tick();
      if (r) begin
        next_a++;
        if (next_a > 8) rd_valid = 1'b0;
        else rd_addr = AW'(next_a);
      end
    end
    check("stream.responses", got, 8);
    rd_valid = 1'b0;

    // --- write plus clear_start on the same edge: write issued, then swept ---
    wr_valid = 1'b1; wr_addr = 8'h10; wr_data = 32'hCAFE_F00D; clear_start = 1'b1;
    tick();
    wr_valid = 1'b0; clear_start = 1'b0;
    check("clr.write_issued", {ram_cs_0, ram_we_0, 22'd0, ram_address_0}, 32'hC000_0010);
    check("clr.write_data",   ram_data_0, 32'hCAFE_F00D);
    check("clr.busy",         32'(clear_busy), 32'd1);
    tick();
    check("clr.mem_before",   mem[8'h10], 32'hCAFE_F00D);
    check("clr.first_addr",   32'(ram_address_0), 32'd0);
    sweep("clr", 255);
    do_read(8'h10);
    wait_rsp("clr.rd10", 8'h10, 32'h0000_0000, 2);

    // --- reset with two reads in flight ---
    rsp_ready = 1'b0;
    rd_valid = 1'b1; rd_addr = 8'h20;
    tick();
    rd_addr = 8'h21;
    tick();
    rd_valid = 1'b0;
    tick();
    check("rst2.valid_before", 32'(rsp_valid), 32'd1);
    check("rst2.addr_before",  32'(rsp_addr), 32'h20);
    rst_n = 1'b0;
    #1;
    check("rst2.valid_now", 32'(rsp_valid), 32'd0);
    check("rst2.cs1_now",   32'(ram_cs_1), 32'd0);
    tick();
    tick();
    rsp_ready = 1'b1;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 300; c++) begin
      if (rsp_valid) stale++;
      tick();
    end
    check("rst2.stale", stale, 0);
    check("rst2.busy_done", 32'(clear_busy), 32'd0);
    do_read(8'h21);
    wait_rsp("rst2.rd21", 8'h21, 32'h0000_0000, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
